// File: rtl/biquad_cascade_if.sv
// Sample/coefficient bus for biquad_cascade.
// master drives lrclk/in/coef_*; slave returns out/out_valid/busy/overrun.
interface biquad_cascade_if #(
  parameter int BITSIZE = 16,
  parameter int COEFW   = 16,
  parameter int STAGES  = 2
);
  localparam int AW = $clog2(STAGES * 5);

  logic                      lrclk;
  logic signed [BITSIZE-1:0] in;
  logic signed [BITSIZE-1:0] out;
  logic                      out_valid;
  logic                      busy;
  logic                      overrun;
  logic                      coef_we;
  logic [AW-1:0]             coef_addr;
  logic signed [COEFW-1:0]   coef_data;

  modport master (
    output lrclk, in, coef_we, coef_addr, coef_data,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  lrclk, in, coef_we, coef_addr, coef_data,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/biquad_cascade.sv
// Cascade of DF-II-T biquads on one shared, registered multiplier.
// Ports: bclk, reset (sync, high), bus (biquad_cascade_if.slave).
// Define BIQUAD_SATURATE_EN to clamp y and saturate d1/d2.
module biquad_cascade #(
  parameter int BITSIZE = 16,
  parameter int COEFW   = 16,
  parameter int FRAC    = 14,
  parameter int STAGES  = 2
) (
  input logic              bclk,
  input logic              reset,
  biquad_cascade_if.slave  bus
);
  localparam int NC   = STAGES * 5;
  localparam int AW   = $clog2(NC);
  localparam int SW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PW   = BITSIZE + COEFW;
  localparam int ACCW = PW + 2;
  localparam logic signed [COEFW-1:0] ONE = COEFW'(1) << FRAC;

  typedef enum logic [1:0] {IDLE, SEC, DRAIN, OUTV} st_t;

  st_t st, nxt;

  logic                      lrclk_q;
  logic                      rise;
  logic                      busy;
  logic                      start;
  logic [2:0]                slot;
  logic [SW-1:0]             sec;
  logic                      last;
  logic signed [COEFW-1:0]   shadow [NC];
  logic signed [COEFW-1:0]   active [NC];
  logic signed [ACCW-1:0]    d1 [STAGES];
  logic signed [ACCW-1:0]    d2 [STAGES];
  logic signed [BITSIZE-1:0] x;
  logic signed [BITSIZE-1:0] y;
  logic signed [PW-1:0]      prod;
  logic signed [ACCW:0]      acc1;
  logic signed [ACCW-1:0]    tmp;

  logic [2:0]                cslot;
  logic [AW-1:0]             cidx;
  logic signed [COEFW-1:0]   csel;
  logic signed [BITSIZE-1:0] opnd;
  logic signed [PW-1:0]      mul;
  logic signed [ACCW:0]      pe1;
  logic signed [ACCW-1:0]    d1s;
  logic signed [ACCW-1:0]    d2s;
  logic signed [ACCW:0]      accy;
  logic signed [ACCW:0]      yshift;
  logic signed [ACCW:0]      d1n;
  logic signed [ACCW:0]      d2n;
  logic signed [BITSIZE-1:0] ysec;
  logic signed [ACCW-1:0]    d1w;
  logic signed [ACCW-1:0]    d2w;

  assign rise    = bus.lrclk & ~lrclk_q;
  // out_valid cycle still counts as busy
  assign busy    = (st != IDLE) | bus.out_valid;
  assign bus.busy = busy;
  assign start   = rise & ~busy;
  assign last    = (sec == SW'(STAGES - 1));

  // slot 5 issues nothing; clamp so the index stays in range
  assign cslot = (slot > 3'd4) ? 3'd4 : slot;
  assign cidx  = AW'(sec) * AW'(5) + AW'(cslot);
  assign csel  = active[cidx];
  assign opnd  = (slot < 3'd3) ? x : y;
  assign mul   = PW'(csel) * PW'(opnd);

  assign pe1    = {{3{prod[PW-1]}}, prod};
  assign d1s    = d1[sec];
  assign d2s    = d2[sec];
  assign accy   = pe1 + {d1s[ACCW-1], d1s};
  assign yshift = accy >>> FRAC;
  assign d1n    = acc1 - pe1;
  assign d2n    = {tmp[ACCW-1], tmp} - pe1;

`ifdef BIQUAD_SATURATE_EN
  function automatic logic signed [BITSIZE-1:0] clamp_y(
    input logic signed [ACCW:0] v
  );
    logic [ACCW-BITSIZE+1:0] hi;
    hi = v[ACCW:BITSIZE-1];
    if ((&hi) || (~|hi)) return v[BITSIZE-1:0];
    return v[ACCW] ? {1'b1, {(BITSIZE-1){1'b0}}}
                   : {1'b0, {(BITSIZE-1){1'b1}}};
  endfunction

  function automatic logic signed [ACCW-1:0] sat_acc(
    input logic signed [ACCW:0] v
  );
    if (v[ACCW] == v[ACCW-1]) return v[ACCW-1:0];
    return v[ACCW] ? {1'b1, {(ACCW-1){1'b0}}}
                   : {1'b0, {(ACCW-1){1'b1}}};
  endfunction

  assign ysec = clamp_y(yshift);
  assign d1w  = sat_acc(d1n);
  assign d2w  = sat_acc(d2n);
`else
  logic unused_wrap;

  assign ysec = yshift[BITSIZE-1:0];
  assign d1w  = d1n[ACCW-1:0];
  assign d2w  = d2n[ACCW-1:0];
  assign unused_wrap = ^{yshift[ACCW:BITSIZE], d1n[ACCW], d2n[ACCW]};
`endif

  always_ff @(posedge bclk) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (start) nxt = SEC;
      SEC:     if (slot == 3'd5 && last) nxt = DRAIN;
      DRAIN:   nxt = OUTV;
      OUTV:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Per section: slot0 a0*x, 1 a1*x + y, 2 a2*x, 3 b1*y,
  // 4 b2*y + d1 update, 5 d2 update (pad slot).
  always_ff @(posedge bclk) begin
    if (reset) begin
      lrclk_q       <= 1'b0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
      slot          <= '0;
      sec           <= '0;
      x             <= '0;
      y             <= '0;
      prod          <= '0;
      acc1          <= '0;
      tmp           <= '0;
      for (int i = 0; i < NC; i++) begin
        shadow[i] <= (i % 5 == 0) ? ONE : '0;
        active[i] <= (i % 5 == 0) ? ONE : '0;
      end
      for (int i = 0; i < STAGES; i++) begin
        d1[i] <= '0;
        d2[i] <= '0;
      end
    end else begin
      lrclk_q       <= bus.lrclk;
      bus.overrun   <= rise & busy;
      bus.out_valid <= 1'b0;
      if (bus.coef_we && ({1'b0, bus.coef_addr} < (AW+1)'(NC)))
        shadow[bus.coef_addr] <= bus.coef_data;
      if (start) begin
        x    <= bus.in;
        slot <= '0;
        sec  <= '0;
        for (int i = 0; i < NC; i++) active[i] <= shadow[i];
      end
      if (st == SEC) begin
        prod <= mul;
        slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
        unique case (slot)
          3'd1: y <= ysec;
          3'd2: acc1 <= pe1 + {d2s[ACCW-1], d2s};
          3'd3: tmp <= pe1[ACCW-1:0];
          3'd4: d1[sec] <= d1w;
          3'd5: begin
            d2[sec] <= d2w;
            x       <= y;
            sec     <= last ? '0 : sec + 1'b1;
          end
          default: ;
        endcase
      end
      if (st == OUTV) begin
        bus.out       <= y;
        bus.out_valid <= 1'b1;
      end
    end
  end
endmodule
